// File: rtl/decode_queue_stage.sv
// Registered RV32I(+M) decode stage with a small decoded-entry FIFO.
// Fetch hands over one instruction per cycle (valid/ready). The decode is
// written into the FIFO tail, and the head is presented downstream (ready/valid).

package decode_queue_pkg;
  typedef struct packed {
    logic       alu1_pc;     // operand A: 0 = rs1, 1 = pc
    logic       alu2_imm;    // operand B: 0 = rs2, 1 = imm
    logic [3:0] alu_op;
    logic [2:0] cmp_op;      // branch-style compare (funct3 encoding)
    logic       branch;
    logic       target_rs1;  // jump target base: 0 = pc, 1 = rs1
    logic [1:0] aluout_sel;  // 0 = alu, 1 = cmp result, 2 = link address
  } ex_ctrl_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic       regf_we;
    logic       wb_mem;      // 0 = alu result, 1 = load data
    logic [2:0] funct3;
  } wb_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    ex_ctrl_t    ex;
    mem_ctrl_t   mem;
    wb_ctrl_t    wb;
    logic        md_valid;
    logic [2:0]  md_op;
    logic        illegal;
  } dec_entry_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_SRA = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_AND = 4'd7;

  localparam logic [2:0] CMP_BEQ  = 3'd0;
  localparam logic [2:0] CMP_BLT  = 3'd4;
  localparam logic [2:0] CMP_BLTU = 3'd6;

  localparam logic [1:0] OUT_ALU  = 2'd0;
  localparam logic [1:0] OUT_CMP  = 2'd1;
  localparam logic [1:0] OUT_ADDR = 2'd2;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_REG   = 7'b0110011;
endpackage

module decode_queue_stage
  import decode_queue_pkg::*;
#(
  parameter int Q_DEPTH = 2,
  parameter bit EN_M    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rs1_addr,
  output logic [4:0]  out_rs2_addr,
  output logic [4:0]  out_rd_addr,
  output logic [31:0] out_imm,
  output ex_ctrl_t    out_ex_ctrl,
  output mem_ctrl_t   out_mem_ctrl,
  output wb_ctrl_t    out_wb_ctrl,
  output logic        out_md_valid,
  output logic [2:0]  out_md_op,
  output logic        out_illegal
);
  localparam int PW = $clog2(Q_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(Q_DEPTH);

  logic [6:0]  opc_s, f7_s;
  logic [2:0]  f3_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  dec_entry_t  dec_s, head_s;
  logic        ill_s, enq_s, deq_s;

  dec_entry_t     q_r [Q_DEPTH];
  logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [PW:0]    count_r;

  assign opc_s   = in_inst[6:0];
  assign rd_s    = in_inst[11:7];
  assign f3_s    = in_inst[14:12];
  assign rs1_s   = in_inst[19:15];
  assign rs2_s   = in_inst[24:20];
  assign f7_s    = in_inst[31:25];
  assign imm_i_s = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b_s = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u_s = {in_inst[31:12], 12'h000};
  assign imm_j_s = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Combinational decode of the incoming instruction into a queue entry.
  always_comb begin
    dec_s = '0;
    ill_s = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      ill_s = 1'b1;
    end else begin
      case (opc_s)
        OPC_LUI: begin
          dec_s.rd_addr = rd_s; dec_s.imm = imm_u_s;
          dec_s.ex.alu2_imm = 1'b1; dec_s.ex.alu_op = ALU_ADD; dec_s.wb.regf_we = 1'b1;
        end
        OPC_AUIPC: begin
          dec_s.rd_addr = rd_s; dec_s.imm = imm_u_s;
          dec_s.ex.alu1_pc = 1'b1; dec_s.ex.alu2_imm = 1'b1; dec_s.ex.alu_op = ALU_ADD;
          dec_s.wb.regf_we = 1'b1;
        end
        OPC_JAL: begin
          dec_s.rd_addr = rd_s; dec_s.imm = imm_j_s;
          dec_s.ex.cmp_op = CMP_BEQ; dec_s.ex.branch = 1'b1; dec_s.ex.aluout_sel = OUT_ADDR;
          dec_s.wb.regf_we = 1'b1;
        end
        OPC_JALR: begin
          if (f3_s != 3'd0) begin
            ill_s = 1'b1;
          end else begin
            // Both compare operands are rs1 so the beq compare always takes the jump.
            dec_s.rs1_addr = rs1_s; dec_s.rs2_addr = rs1_s; dec_s.rd_addr = rd_s; dec_s.imm = imm_i_s;
            dec_s.ex.cmp_op = CMP_BEQ; dec_s.ex.target_rs1 = 1'b1; dec_s.ex.branch = 1'b1;
            dec_s.ex.aluout_sel = OUT_ADDR; dec_s.wb.regf_we = 1'b1;
          end
        end
        OPC_BR: begin
          if ((f3_s == 3'd2) || (f3_s == 3'd3)) begin
            ill_s = 1'b1;
          end else begin
            dec_s.rs1_addr = rs1_s; dec_s.rs2_addr = rs2_s; dec_s.imm = imm_b_s;
            dec_s.ex.cmp_op = f3_s; dec_s.ex.branch = 1'b1;
          end
        end
        OPC_LOAD: begin
          if ((f3_s == 3'd3) || (f3_s == 3'd6) || (f3_s == 3'd7)) begin
            ill_s = 1'b1;
          end else begin
            dec_s.rs1_addr = rs1_s; dec_s.rd_addr = rd_s; dec_s.imm = imm_i_s;
            dec_s.ex.alu2_imm = 1'b1; dec_s.ex.alu_op = ALU_ADD;
            dec_s.mem.mem_read = 1'b1; dec_s.mem.funct3 = f3_s;
            dec_s.wb.regf_we = 1'b1; dec_s.wb.wb_mem = 1'b1; dec_s.wb.funct3 = f3_s;
          end
        end
        OPC_STORE: begin
          if (f3_s > 3'd2) begin
            ill_s = 1'b1;
          end else begin
            dec_s.rs1_addr = rs1_s; dec_s.rs2_addr = rs2_s; dec_s.imm = imm_s_s;
            dec_s.ex.alu2_imm = 1'b1; dec_s.ex.alu_op = ALU_ADD;
            dec_s.mem.mem_write = 1'b1; dec_s.mem.funct3 = f3_s;
          end
        end
        OPC_IMM: begin
          dec_s.rs1_addr = rs1_s; dec_s.rd_addr = rd_s; dec_s.imm = imm_i_s;
          dec_s.ex.alu2_imm = 1'b1; dec_s.wb.regf_we = 1'b1;
          case (f3_s)
            3'd0: dec_s.ex.alu_op = ALU_ADD;
            3'd1: begin
              if (f7_s != 7'h00) ill_s = 1'b1;
              else dec_s.ex.alu_op = ALU_SLL;
            end
            3'd2: begin dec_s.ex.cmp_op = CMP_BLT;  dec_s.ex.aluout_sel = OUT_CMP; end
            3'd3: begin dec_s.ex.cmp_op = CMP_BLTU; dec_s.ex.aluout_sel = OUT_CMP; end
            3'd4: dec_s.ex.alu_op = ALU_XOR;
            3'd5: begin
              if (f7_s == 7'h00) dec_s.ex.alu_op = ALU_SRL;
              else if (f7_s == 7'h20) dec_s.ex.alu_op = ALU_SRA;
              else ill_s = 1'b1;
            end
            3'd6: dec_s.ex.alu_op = ALU_OR;
            3'd7: dec_s.ex.alu_op = ALU_AND;
            default: ill_s = 1'b1;
          endcase
        end
        OPC_REG: begin
          dec_s.rs1_addr = rs1_s; dec_s.rs2_addr = rs2_s; dec_s.rd_addr = rd_s;
          dec_s.wb.regf_we = 1'b1;
          if (EN_M && (f7_s == 7'h01)) begin
            dec_s.md_valid = 1'b1; dec_s.md_op = f3_s;
          end else if (f7_s == 7'h00) begin
            case (f3_s)
              3'd0: dec_s.ex.alu_op = ALU_ADD;
              3'd1: dec_s.ex.alu_op = ALU_SLL;
              3'd2: begin dec_s.ex.cmp_op = CMP_BLT;  dec_s.ex.aluout_sel = OUT_CMP; end
              3'd3: begin dec_s.ex.cmp_op = CMP_BLTU; dec_s.ex.aluout_sel = OUT_CMP; end
              3'd4: dec_s.ex.alu_op = ALU_XOR;
              3'd5: dec_s.ex.alu_op = ALU_SRL;
              3'd6: dec_s.ex.alu_op = ALU_OR;
              3'd7: dec_s.ex.alu_op = ALU_AND;
              default: ill_s = 1'b1;
            endcase
          end else if (f7_s == 7'h20) begin
            case (f3_s)
              3'd0: dec_s.ex.alu_op = ALU_SUB;
              3'd5: dec_s.ex.alu_op = ALU_SRA;
              default: ill_s = 1'b1;
            endcase
          end else begin
            ill_s = 1'b1;
          end
        end
        default: ill_s = 1'b1;
      endcase
    end
    // Illegal entries carry only the pc and the illegal flag; x0 never gets written.
    if (ill_s) begin
      dec_s = '0;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.wb.regf_we = dec_s.wb.regf_we & (dec_s.rd_addr != 5'd0);
    end
    dec_s.pc = in_pc;
  end

  assign in_ready  = (count_r != FULL_CNT);
  assign out_valid = (count_r != '0);
  assign enq_s     = in_valid & in_ready & ~flush;
  assign deq_s     = out_valid & out_ready & ~flush;

  // FIFO storage, pointers and occupancy; flush wins over enqueue and dequeue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < Q_DEPTH; i++) q_r[i] <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_s) begin
        q_r[wr_ptr_r] <= dec_s;
        wr_ptr_r      <= wr_ptr_r + PW'(1);
      end
      if (deq_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_s       = q_r[rd_ptr_r];
  assign out_pc       = head_s.pc;
  assign out_rs1_addr = head_s.rs1_addr;
  assign out_rs2_addr = head_s.rs2_addr;
  assign out_rd_addr  = head_s.rd_addr;
  assign out_imm      = head_s.imm;
  assign out_ex_ctrl  = head_s.ex;
  assign out_mem_ctrl = head_s.mem;
  assign out_wb_ctrl  = head_s.wb;
  assign out_md_valid = head_s.md_valid;
  assign out_md_op    = head_s.md_op;
  assign out_illegal  = head_s.illegal;
endmodule
